// File: rtl/reg_mask_sequencer.sv
// Register-mask walker: issues one register index per accepted transfer, lowest set bit first.
// Define REG_SEQ_DESCEND_EN to issue the highest set bit first instead (push-multiple order).
module reg_mask_sequencer #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 5
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic [(1<<IDX_W)-1:0] mask,
    input  logic                  idx_ready,
    output logic                  idx_valid,
    output logic [IDX_W-1:0]      idx,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      count,
    output logic [1:0]            fsm_state
);
    localparam int NREGS = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [NREGS-1:0] pending, pending_nx;
    logic [CNT_W-1:0] count_q, count_nx;
    logic [IDX_W-1:0] pick;
    logic [NREGS-1:0] pick_bit;
    logic [NREGS-1:0] remaining;

    // Priority pick: the last matching iteration wins, so scan order sets the priority.
    always_comb begin
        pick = '0;
`ifdef REG_SEQ_DESCEND_EN
        for (int i = 0; i < NREGS; i++) begin
            if (pending[i]) pick = IDX_W'(i);
        end
`else
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (pending[i]) pick = IDX_W'(i);
        end
`endif
    end

    assign pick_bit  = NREGS'(1) << pick;
    assign remaining = pending & ~pick_bit;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= IDLE;
            pending <= '0;
            count_q <= '0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
            count_q <= count_nx;
        end
    end

    // Handshake: an index transfers on a rising edge where idx_valid and idx_ready are both
    // high; while idx_valid is high and idx_ready is low, idx is held unchanged.
    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        count_nx   = count_q;
        idx_valid  = 1'b0;
        idx        = '0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    pending_nx = mask;
                    count_nx   = '0;
                    state_nx   = (mask != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                idx_valid = 1'b1;
                idx       = pick;
                if (idx_ready) begin
                    pending_nx = remaining;
                    count_nx   = count_q + CNT_W'(1);
                    if (remaining == '0) state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign count     = count_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_reg_mask_sequencer.sv
// Bench for reg_mask_sequencer: directed table, hand-written corner sequences, random masks.
module tb_reg_mask_sequencer;
    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        idx_ready = 1'b0;
    logic [15:0] mask = 16'h0000;
    logic        idx_valid, busy, done;
    logic [3:0]  idx;
    logic [4:0]  count;
    logic [1:0]  fsm_state;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  exp_q[$];

    typedef struct {
        logic [15:0] mask;
        int          mode;       // 0 ready always, 1 ready alternating 0/1, 3 ready always + start poke
        int          exp_count;
        int          exp_cycles; // RUN cycles until the last index is accepted
    } vec_t;
    vec_t vecs[6];

    reg_mask_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .mask      (mask),
        .idx_ready (idx_ready),
        .idx_valid (idx_valid),
        .idx       (idx),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .fsm_state (fsm_state)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference order: the set bits of the mask, sorted by register number.
    function automatic void build_order(input logic [15:0] m);
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
`ifdef REG_SEQ_DESCEND_EN
                exp_q.push_front(4'(i));
`else
                exp_q.push_back(4'(i));
`endif
            end
        end
    endfunction

    task automatic run_op(input string tag, input logic [15:0] m, input int mode, output int cycles);
        int   n;
        int   cyc;
        logic rdy;
        build_order(m);
        n   = exp_q.size();
        cyc = 0;
        @(negedge clock);
        start = 1'b1;
        mask  = m;
        @(posedge clock); #1;
        start = 1'b0;
        mask  = 16'($urandom);
        while (exp_q.size() > 0 && cyc < 200) begin
            case (mode)
                0, 3:    rdy = 1'b1;
                1:       rdy = cyc[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (mode == 3 && cyc == 1) begin
                start = 1'b1;
                mask  = 16'h0001;
            end else begin
                start = 1'b0;
            end
            idx_ready = rdy;
            @(negedge clock);
            check({tag, " idx_valid"}, 32'(idx_valid), 32'(1));
            check({tag, " idx"}, 32'(idx), 32'(exp_q[0]));
            check({tag, " busy_run"}, 32'(busy), 32'(1));
            check({tag, " done_run"}, 32'(done), 32'(0));
            @(posedge clock); #1;
            if (rdy) void'(exp_q.pop_front());
            cyc++;
        end
        start = 1'b0;
        check({tag, " timeout"}, 32'(exp_q.size()), 32'(0));
        idx_ready = 1'($urandom_range(0, 1));
        @(negedge clock);
        check({tag, " done"}, 32'(done), 32'(1));
        check({tag, " valid_done"}, 32'(idx_valid), 32'(0));
        check({tag, " idx_done"}, 32'(idx), 32'(0));
        check({tag, " busy_done"}, 32'(busy), 32'(1));
        check({tag, " count_done"}, 32'(count), 32'(n));
        @(negedge clock);
        check({tag, " busy_idle"}, 32'(busy), 32'(0));
        check({tag, " done_idle"}, 32'(done), 32'(0));
        check({tag, " count_idle"}, 32'(count), 32'(n));
        idx_ready = 1'b0;
        cycles = cyc;
    endtask

    initial begin
        int          cyc;
        logic [15:0] m;

        vecs[0] = '{16'h0000, 0, 0, 0};
        vecs[1] = '{16'h8421, 0, 4, 4};
        vecs[2] = '{16'hFFFF, 1, 16, 32};
        vecs[3] = '{16'h00F0, 3, 4, 4};
        vecs[4] = '{16'h0001, 0, 1, 1};
        vecs[5] = '{16'h8000, 0, 1, 1};

        // Reset state
        #12;
        check("rst idx_valid", 32'(idx_valid), 32'(0));
        check("rst idx", 32'(idx), 32'(0));
        check("rst busy", 32'(busy), 32'(0));
        check("rst done", 32'(done), 32'(0));
        check("rst count", 32'(count), 32'(0));
        @(negedge clock);
        clear = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].mask, vecs[v].mode, cyc);
            check($sformatf("vec%0d cycles", v), 32'(cyc), 32'(vecs[v].exp_cycles));
            check($sformatf("vec%0d count", v), 32'(count), 32'(vecs[v].exp_count));
        end

        // Asynchronous clear while index 5 is on offer with one transfer already counted
        @(negedge clock);
        start = 1'b1;
        mask = 16'h0021;
        idx_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        idx_ready = 1'b0;
        @(negedge clock);
`ifdef REG_SEQ_DESCEND_EN
        check("pre_clear idx", 32'(idx), 32'(0));
`else
        check("pre_clear idx", 32'(idx), 32'(5));
`endif
        check("pre_clear count", 32'(count), 32'(1));
        #1 clear = 1'b0;
        #1;
        check("async idx_valid", 32'(idx_valid), 32'(0));
        check("async idx", 32'(idx), 32'(0));
        check("async busy", 32'(busy), 32'(0));
        check("async count", 32'(count), 32'(0));
        @(negedge clock);
        clear = 1'b1;
        run_op("resume", 16'h0002, 0, cyc);
        check("resume count", 32'(count), 32'(1));

        // Back-to-back: start held through DONE is only taken on the following IDLE edge
        @(negedge clock);
        start = 1'b1;
        mask = 16'h0001;
        idx_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        start = 1'b1;
        mask = 16'h0002;
        @(negedge clock);
        check("b2b done", 32'(done), 32'(1));
        @(negedge clock);
        check("b2b idle busy", 32'(busy), 32'(0));
        @(posedge clock); #1;
        start = 1'b0;
        mask = 16'($urandom);
        @(negedge clock);
        check("b2b valid", 32'(idx_valid), 32'(1));
        check("b2b idx", 32'(idx), 32'(1));
        check("b2b count0", 32'(count), 32'(0));
        @(negedge clock);
        check("b2b done2", 32'(done), 32'(1));
        check("b2b count1", 32'(count), 32'(1));
        idx_ready = 1'b0;

        // Random masks with random consumer stalls
        for (int r = 0; r < 25; r++) begin
            m = 16'($urandom);
            if (r % 3 == 0) m = m & 16'($urandom);
            if (r % 7 == 0) m = 16'h0000;
            run_op($sformatf("rnd%0d", r), m, 2, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
